// File: rtl/uart_rx_stream_pkg.sv
// Shared definitions for the stream UART receiver: parity modes, receiver FSM states
// and the parity check used on the parity-bit sample.
package uart_rx_stream_pkg;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_EVEN = 1;
  localparam int UART_PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_PUSH,
    ST_WAIT_HI
  } rx_state_t;

  // Data is zero-extended to 9 bits, which leaves its XOR reduction unchanged.
  function automatic logic parity_error(input logic [8:0] data, input logic sample, input int mode);
    return (^data ^ sample) != (mode == UART_PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_stream_fifo.sv
// Synchronous character FIFO. A push while full is stored only when the head pops
// in the same cycle; otherwise it is dropped and flagged on overrun.
module uart_rx_stream_fifo #(
  parameter int p_width = 10,
  parameter int p_depth = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [p_width-1:0] wdata,
  input  logic               ready,
  output logic [p_width-1:0] rdata,
  output logic               dv,
  output logic               overrun
);

  localparam int AW = $clog2(p_depth);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [p_width-1:0] mem [p_depth];
  logic               empty;
  logic               full;
  logic               pop;
  logic               do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && ready;
  assign do_push = push && (!full || pop);
  assign overrun = push && full && !pop;
  assign dv      = !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset: a slot only becomes visible once the write pointer passes it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_stream.sv
// Oversampling UART receiver: mid-bit samples of a synchronised line are assembled into
// characters and queued, with parity/frame flags, for a valid/ready consumer.
module uart_rx_stream
  import uart_rx_stream_pkg::*;
#(
  parameter int p_preescaler = 8,
  parameter int p_oversample = 16,
  parameter int p_data_bits  = 8,
  parameter int p_parity     = 0,
  parameter int p_stop_bits  = 1,
  parameter int p_fifo_depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rx,
  output logic [p_data_bits-1:0] orp_data,
  output logic                   or_parity_err,
  output logic                   or_frame_err,
  output logic                   or_dv,
  input  logic                   i_ready,
  output logic                   or_overrun
);

  localparam int PW = (p_preescaler > 1) ? $clog2(p_preescaler) : 1;
  localparam int OW = $clog2(p_oversample);
  localparam int BW = $clog2(p_data_bits + 1);
  localparam int FW = p_data_bits + 2;

  logic [PW-1:0]          presc_cnt;
  logic                   tick;
  logic                   rx_meta;
  logic                   rx_s;
  rx_state_t              state;
  logic [OW-1:0]          os_cnt;
  logic                   os_wrap;
  logic [BW-1:0]          bit_cnt;
  logic [p_data_bits-1:0] data;
  logic                   perr;
  logic                   ferr;
  logic                   push;
  logic [FW-1:0]          fifo_rdata;

  assign tick    = (presc_cnt == PW'(p_preescaler - 1));
  assign os_wrap = (os_cnt == OW'(p_oversample - 1));
  assign push    = (state == ST_PUSH);

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
      rx_meta   <= i_rx;
      rx_s      <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      data    <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick && !rx_s) begin
            state  <= ST_START;
            os_cnt <= '0;
          end
        end
        // Start bit must still be low half a bit later, else it was a glitch.
        ST_START: begin
          if (tick) begin
            if (os_cnt == OW'(p_oversample / 2 - 1)) begin
              if (!rx_s) begin
                state   <= ST_DATA;
                os_cnt  <= '0;
                bit_cnt <= '0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              os_cnt <= os_cnt + OW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (os_wrap) begin
              os_cnt <= '0;
              data   <= {rx_s, data[p_data_bits-1:1]};
              if (bit_cnt == BW'(p_data_bits - 1)) begin
                bit_cnt <= '0;
                state   <= (p_parity != UART_PAR_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              os_cnt <= os_cnt + OW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            if (os_wrap) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              perr    <= parity_error(9'(data), rx_s, p_parity);
              state   <= ST_STOP;
            end else begin
              os_cnt <= os_cnt + OW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (os_wrap) begin
              os_cnt <= '0;
              if (!rx_s) ferr <= 1'b1;
              if (bit_cnt == BW'(p_stop_bits - 1)) begin
                state <= ST_PUSH;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              os_cnt <= os_cnt + OW'(1);
            end
          end
        end
        // A bad stop bit may be a break; wait for the line to return high first.
        ST_PUSH:    state <= ferr ? ST_WAIT_HI : ST_IDLE;
        ST_WAIT_HI: if (tick && rx_s) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  uart_rx_stream_fifo #(
    .p_width (FW),
    .p_depth (p_fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   ({perr, ferr, data}),
    .ready   (i_ready),
    .rdata   (fifo_rdata),
    .dv      (or_dv),
    .overrun (or_overrun)
  );

  assign {or_parity_err, or_frame_err, orp_data} = fifo_rdata;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench: three receivers (8N1, 8E1, 9N2) at 32 clk/bit, driven from one
// frame generator; received characters are compared against a reference model and tables.
module tb_uart_rx_stream;

  localparam int BIT = 32;

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  logic ready = 1'b0;
  bit   rand_ready = 1'b0;
  int   sel = 0;

  int tests = 0;
  int fails = 0;
  int ovc8 = 0;
  int ovcp = 0;
  int ovc9 = 0;

  logic [10:0] q8[$];
  logic [10:0] qp[$];
  logic [10:0] q9[$];

  logic       rx8, rxp, rx9;
  logic [7:0] d8, dp;
  logic [8:0] d9;
  logic       pe8, fe8, dv8, ov8;
  logic       pep, fep, dvp, ovp;
  logic       pe9, fe9, dv9, ov9;

  assign rx8 = (sel == 0) ? line : 1'b1;
  assign rxp = (sel == 1) ? line : 1'b1;
  assign rx9 = (sel == 2) ? line : 1'b1;

  always #5 clk = ~clk;

  uart_rx_stream #(.p_preescaler(4), .p_oversample(8), .p_data_bits(8), .p_parity(0),
                   .p_stop_bits(1), .p_fifo_depth(4)) dut8 (
    .clk(clk), .rst(rst), .i_rx(rx8), .orp_data(d8), .or_parity_err(pe8),
    .or_frame_err(fe8), .or_dv(dv8), .i_ready(ready), .or_overrun(ov8));

  uart_rx_stream #(.p_preescaler(4), .p_oversample(8), .p_data_bits(8), .p_parity(1),
                   .p_stop_bits(1), .p_fifo_depth(4)) dutp (
    .clk(clk), .rst(rst), .i_rx(rxp), .orp_data(dp), .or_parity_err(pep),
    .or_frame_err(fep), .or_dv(dvp), .i_ready(ready), .or_overrun(ovp));

  uart_rx_stream #(.p_preescaler(4), .p_oversample(8), .p_data_bits(9), .p_parity(0),
                   .p_stop_bits(2), .p_fifo_depth(4)) dut9 (
    .clk(clk), .rst(rst), .i_rx(rx9), .orp_data(d9), .or_parity_err(pe9),
    .or_frame_err(fe9), .or_dv(dv9), .i_ready(ready), .or_overrun(ov9));

  // Every accepted head character is logged as {perr, ferr, data[8:0]}.
  always @(negedge clk) begin
    if (!rst) begin
      if (dv8 && ready) q8.push_back({pe8, fe8, 1'b0, d8});
      if (dvp && ready) qp.push_back({pep, fep, 1'b0, dp});
      if (dv9 && ready) q9.push_back({pe9, fe9, d9});
      if (ov8) ovc8++;
      if (ovp) ovcp++;
      if (ov9) ovc9++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish within 100000 clocks");
    $fatal(1, "[TB] aborting");
  end

  function automatic logic [10:0] model_char(input int nbits, input logic [8:0] data,
                                             input int par_mode, input logic par_bit,
                                             input logic stop_bit);
    logic [8:0] d;
    int         ones;
    logic       perr;
    d    = data & 9'((1 << nbits) - 1);
    ones = $countones(d) + int'(par_bit);
    if (par_mode == 0)      perr = 1'b0;
    else if (par_mode == 1) perr = (ones % 2) == 1;
    else                    perr = (ones % 2) == 0;
    return {perr, ~stop_bit, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Drives one frame on the selected receiver's line; stop_bit applies to the first stop bit.
  task automatic applyStimulus(input int which, input int nbits, input logic [8:0] data,
                               input int par_mode, input logic par_bit, input int nstop,
                               input logic stop_bit, input int gap_bits);
    sel  = which;
    line = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < nbits; i++) begin
      line = data[i];
      wait_clks(BIT);
    end
    if (par_mode != 0) begin
      line = par_bit;
      wait_clks(BIT);
    end
    for (int s = 0; s < nstop; s++) begin
      line = (s == 0) ? stop_bit : 1'b1;
      wait_clks(BIT);
    end
    line = 1'b1;
    wait_clks(gap_bits * BIT);
  endtask

  task automatic expect_char(input string name, input int which, input logic [10:0] exp);
    logic [10:0] got;
    bit          have;
    have = 1'b0;
    got  = '0;
    case (which)
      0: if (q8.size() > 0) begin got = q8.pop_front(); have = 1'b1; end
      1: if (qp.size() > 0) begin got = qp.pop_front(); have = 1'b1; end
      default: if (q9.size() > 0) begin got = q9.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: got no character, expected %0h", name, exp);
    end else begin
      checkOutput(name, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    vec_t        vecs[8];
    logic [10:0] exp8[$];
    logic [8:0]  rdata;
    bit          bad;
    int          gap;
    int          base;

    vecs[0] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_dut8", {dv8, ov8, pe8, fe8, d8}, 32'h0);
    checkOutput("reset_dutp", {dvp, ovp, pep, fep, dp}, 32'h0);
    checkOutput("reset_dut9", {dv9, ov9, pe9, fe9, d9}, 32'h0);
    @(posedge clk);
    #1;

    // 8N1 0xA5: or_dv rises the cycle after the push and pulses once.
    ready = 1'b1;
    fork
      applyStimulus(0, 8, 9'h0A5, 0, 1'b0, 1, 1'b1, 1);
      begin : lat_watch
        int n;
        n = 0;
        @(negedge clk);
        while (!dut8.push && n < 2000) begin
          @(negedge clk);
          n++;
        end
        if (!dut8.push) begin
          checkOutput("a5_push_timeout", 32'(n), 32'(0));
        end else begin
          checkOutput("a5_dv_at_push", 32'(dv8), 32'(0));
          @(negedge clk);
          checkOutput("a5_dv_rise", 32'(dv8), 32'(1));
          checkOutput("a5_head", {pe8, fe8, d8}, 32'h0A5);
          @(negedge clk);
          checkOutput("a5_dv_pulse", 32'(dv8), 32'(0));
        end
      end
    join
    expect_char("a5_char", 0, 11'h0A5);
    checkOutput("a5_single", 32'(q8.size()), 32'(0));

    // Even-parity receiver against the hand-written table.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 8, {1'b0, vecs[i].data}, 1, vecs[i].par_bit, 1, vecs[i].stop_bit, 1);
      expect_char($sformatf("par_vec%0d", i), 1,
                  {vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0, vecs[i].data});
    end
    checkOutput("par_no_overrun", 32'(ovcp), 32'(0));

    // Four-tick low glitch on an idle line must not start a character.
    line = 1'b0;
    sel  = 0;
    wait_clks(16);
    line = 1'b1;
    wait_clks(3 * BIT);
    checkOutput("glitch_no_char", 32'(q8.size()), 32'(0));
    checkOutput("glitch_dv", 32'(dv8), 32'(0));

    // Bad stop bit followed by a 20-bit break, then a clean character.
    applyStimulus(0, 8, 9'h081, 0, 1'b0, 1, 1'b0, 0);
    line = 1'b0;
    wait_clks(20 * BIT);
    expect_char("break_ferr", 0, 11'h281);
    checkOutput("break_single", 32'(q8.size()), 32'(0));
    line = 1'b1;
    wait_clks(2 * BIT);
    applyStimulus(0, 8, 9'h03C, 0, 1'b0, 1, 1'b1, 1);
    expect_char("break_recover", 0, 11'h03C);
    checkOutput("break_tail", 32'(q8.size()), 32'(0));

    // Five characters into a depth-4 FIFO with no consumer.
    ready = 1'b0;
    base  = ovc8;
    for (int i = 0; i < 5; i++) applyStimulus(0, 8, 9'(8'h10 + i), 0, 1'b0, 1, 1'b1, 1);
    checkOutput("ovr_pulse_count", 32'(ovc8 - base), 32'(1));
    checkOutput("ovr_dv_held", 32'(dv8), 32'(1));
    ready = 1'b1;
    wait_clks(8);
    for (int i = 0; i < 4; i++) expect_char($sformatf("ovr_drain%0d", i), 0, 11'(8'h10 + i));
    checkOutput("ovr_drain_count", 32'(q8.size()), 32'(0));

    // Same again, but a single-cycle pop coincides with the fifth push.
    ready = 1'b0;
    base  = ovc8;
    for (int i = 0; i < 4; i++) applyStimulus(0, 8, 9'(8'h20 + i), 0, 1'b0, 1, 1'b1, 1);
    fork
      applyStimulus(0, 8, 9'h024, 0, 1'b0, 1, 1'b1, 1);
      begin : pop_watch
        int n;
        n = 0;
        while (!dut8.push && n < 2000) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (!dut8.push) begin
          checkOutput("ovr2_push_timeout", 32'(n), 32'(0));
        end else begin
          ready = 1'b1;
          @(posedge clk);
          #1;
          ready = 1'b0;
        end
      end
    join
    checkOutput("ovr2_no_pulse", 32'(ovc8 - base), 32'(0));
    checkOutput("ovr2_one_popped", 32'(q8.size()), 32'(1));
    ready = 1'b1;
    wait_clks(8);
    for (int i = 0; i < 5; i++) expect_char($sformatf("ovr2_drain%0d", i), 0, 11'(8'h20 + i));
    checkOutput("ovr2_drain_count", 32'(q8.size()), 32'(0));

    // Randomised 8N1 traffic with a random consumer, checked against the model.
    rand_ready = 1'b1;
    base       = ovc8;
    for (int i = 0; i < 30; i++) begin
      rdata = 9'($urandom_range(0, 255));
      bad   = ($urandom_range(0, 7) == 0);
      gap   = bad ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      exp8.push_back(model_char(8, rdata, 0, 1'b0, !bad));
      applyStimulus(0, 8, rdata, 0, 1'b0, 1, !bad, gap);
    end
    rand_ready = 1'b0;
    ready      = 1'b1;
    wait_clks(2 * BIT);
    for (int i = 0; i < 30; i++) expect_char($sformatf("rand%0d", i), 0, exp8[i]);
    checkOutput("rand_leftover", 32'(q8.size()), 32'(0));
    checkOutput("rand_no_overrun", 32'(ovc8 - base), 32'(0));

    // 9-bit, two stop bits, back to back.
    applyStimulus(2, 9, 9'h1FF, 0, 1'b0, 2, 1'b1, 0);
    applyStimulus(2, 9, 9'h001, 0, 1'b0, 2, 1'b1, 1);
    expect_char("b2b_first", 2, model_char(9, 9'h1FF, 0, 1'b0, 1'b1));
    expect_char("b2b_second", 2, model_char(9, 9'h001, 0, 1'b0, 1'b1));

    // Reset mid-frame with a character still queued.
    ready = 1'b0;
    applyStimulus(2, 9, 9'h0AA, 0, 1'b0, 2, 1'b1, 1);
    checkOutput("rst_pre_dv", 32'(dv9), 32'(1));
    line = 1'b0;
    wait_clks(3 * BIT);
    rst  = 1'b1;
    line = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_outputs", {dv9, ov9, pe9, fe9, d9}, 32'h0);
    @(posedge clk);
    #1;
    wait_clks(2 * BIT);
    checkOutput("rst_no_char", 32'(dv9), 32'(0));
    ready = 1'b1;
    applyStimulus(2, 9, 9'h155, 0, 1'b0, 2, 1'b1, 1);
    expect_char("rst_recover", 2, model_char(9, 9'h155, 0, 1'b0, 1'b1));
    checkOutput("rst_tail", 32'(q9.size()), 32'(0));
    checkOutput("dut9_no_overrun", 32'(ovc9), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
